// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: gshare direction predictor with execute-stage resolution, training and GHR repair.
// Optional BP_STATS_EN macro enables the resolved-branch and mispredict counters.
module branch_predict_ctrl #(
   parameter int         IDX_W    = 6,
   parameter logic [1:0] CNT_INIT = 2'b01
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] pcD,
   input  logic        is_branchD,
   input  logic        stallE,
   input  logic        flushE,
   input  logic        branch_takeE,
   output logic        pred_takeD,
   output logic        pred_takeE,
   output logic        mispredictE,
   output logic [31:0] br_cnt,
   output logic [31:0] mis_cnt
);
   logic [1:0]       pht [2**IDX_W];
   logic [1:0]       cnt_nxt;
   logic [IDX_W-1:0] ghr_spec, ghr_commit, ghr_spec_nxt, idxD, idxE;
   logic             validE, commit;
   logic             unused_pc;
   assign unused_pc = ^{pcD[31:IDX_W+2], pcD[1:0]};
   always_comb begin
      idxD         = pcD[IDX_W+1:2] ^ ghr_spec;
      pred_takeD   = is_branchD & pht[idxD][1];
      mispredictE  = validE & (pred_takeE != branch_takeE);
      commit       = validE & ~stallE;
      cnt_nxt      = branch_takeE ? (pht[idxE] == 2'b11 ? 2'b11 : pht[idxE] + 2'd1)
                                  : (pht[idxE] == 2'b00 ? 2'b00 : pht[idxE] - 2'd1);
      // a committing mispredict rebuilds history from the architectural GHR, dropping the wrong-path shift
      ghr_spec_nxt = mispredictE ? {ghr_commit[IDX_W-2:0], branch_takeE}
                   : is_branchD  ? {ghr_spec[IDX_W-2:0], pred_takeD}
                   : ghr_spec;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 2**IDX_W; i++) pht[i] <= CNT_INIT;
      end else if (commit) begin
         pht[idxE] <= cnt_nxt;
      end
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         validE     <= 1'b0;
         idxE       <= '0;
         pred_takeE <= 1'b0;
         ghr_spec   <= '0;
         ghr_commit <= '0;
      end else if (!stallE) begin
         validE     <= is_branchD & ~flushE & ~mispredictE;
         idxE       <= idxD;
         pred_takeE <= pred_takeD;
         ghr_spec   <= ghr_spec_nxt;
         if (validE) ghr_commit <= {ghr_commit[IDX_W-2:0], branch_takeE};
      end
   end
`ifdef BP_STATS_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         br_cnt  <= '0;
         mis_cnt <= '0;
      end else if (commit) begin
         br_cnt <= br_cnt + 32'd1;
         if (mispredictE) mis_cnt <= mis_cnt + 32'd1;
      end
   end
`else
   assign br_cnt  = '0;
   assign mis_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: scoreboard bench for branch_predict_ctrl; E-slot expectations queue up at advance.
module tb_branch_predict_ctrl;
   logic        clk = 1'b0, resetn = 1'b0;
   logic [31:0] pcD = '0;
   logic        is_branchD = 1'b0, stallE = 1'b0, flushE = 1'b0, branch_takeE = 1'b0;
   logic        pred_takeD, pred_takeE, mispredictE;
   logic [31:0] br_cnt, mis_cnt;
   int          checks = 0, errors = 0;
   typedef struct packed {logic v; logic p; logic [5:0] idx;} slot_t;
   slot_t       q[$];
   logic [1:0]  m_pht [64];
   logic [5:0]  m_gs, m_gc;
   logic [31:0] m_br, m_mis;
   logic        tk;
   localparam logic [31:0] P = 32'h0040_0010;

   branch_predict_ctrl dut (
      .clk(clk), .resetn(resetn), .pcD(pcD), .is_branchD(is_branchD), .stallE(stallE),
      .flushE(flushE), .branch_takeE(branch_takeE), .pred_takeD(pred_takeD),
      .pred_takeE(pred_takeE), .mispredictE(mispredictE), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_pht[i] = 2'b01;
      m_gs = '0; m_gc = '0; m_br = '0; m_mis = '0;
      q.delete();
      q.push_back('0);
   endtask

   task automatic cyc(input logic [31:0] pc, input logic br, input logic st, input logic fl, input logic t);
      slot_t e;
      logic [5:0] idx;
      logic pd, mis;
      @(posedge clk); #1;
      pcD = pc; is_branchD = br; stallE = st; flushE = fl; branch_takeE = t;
      @(negedge clk);
      e   = q[0];
      idx = pc[7:2] ^ m_gs;
      pd  = br & m_pht[idx][1];
      mis = e.v & (e.p != t);
      check("pred_takeD", {31'd0, pred_takeD}, {31'd0, pd});
      check("pred_takeE", {31'd0, pred_takeE}, {31'd0, e.p});
      check("mispredictE", {31'd0, mispredictE}, {31'd0, mis});
`ifdef BP_STATS_EN
      check("br_cnt", br_cnt, m_br);
      check("mis_cnt", mis_cnt, m_mis);
`else
      check("br_cnt_tied", br_cnt, 32'd0);
      check("mis_cnt_tied", mis_cnt, 32'd0);
`endif
      if (!st) begin
         if (mis) m_gs = {m_gc[4:0], t};
         else if (br) m_gs = {m_gs[4:0], pd};
         if (e.v) begin
            if (t && m_pht[e.idx] != 2'b11) m_pht[e.idx] = m_pht[e.idx] + 2'd1;
            if (!t && m_pht[e.idx] != 2'b00) m_pht[e.idx] = m_pht[e.idx] - 2'd1;
            m_gc = {m_gc[4:0], t};
            m_br++;
            if (mis) m_mis++;
         end
         void'(q.pop_front());
         q.push_back({br & ~fl & ~mis, pd, idx});
      end
   endtask

   task automatic rand_cycles(input int n);
      for (int i = 0; i < n; i++)
         cyc(32'h0040_0000 + ($urandom_range(0, 15) << 2), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, 1'($urandom_range(0, 1)));
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_pred_takeE", {31'd0, pred_takeE}, 32'd0);
      check("rst_mispredictE", {31'd0, mispredictE}, 32'd0);
      check("rst_br_cnt", br_cnt, 32'd0);
      check("rst_mis_cnt", mis_cnt, 32'd0);
      resetn = 1'b1;
      // cold lookup at idx 4, then taken resolution mispredicts and repairs history to 1
      cyc(P, 1, 0, 0, 0);
      check("cold_pred", {31'd0, pred_takeD}, 32'd0);
      cyc(P, 1, 0, 0, 1);
      check("cold_mispredict", {31'd0, mispredictE}, 32'd1);
      cyc(P, 1, 0, 0, 0);
      check("ghr_idx5_pred", {31'd0, pred_takeD}, 32'd0);
      check("wrong_path_dropped", {31'd0, mispredictE}, 32'd0);
      cyc(P, 0, 0, 0, 0);
      // always-taken stream converges history to all ones and saturates that counter
      repeat (40) cyc(P, 1, 0, 0, 1);
      check("sat_taken_pred", {31'd0, pred_takeD}, 32'd1);
      repeat (40) cyc(P, 1, 0, 0, 0);
      check("sat_not_taken_pred", {31'd0, pred_takeD}, 32'd0);
      // stalled mispredict stays asserted and commits once
      cyc(P + 32'd4, 1, 0, 0, 0);
      tk = ~q[0].p;
      for (int i = 0; i < 3; i++) begin
         cyc(32'd0, 0, 1, 0, tk);
         check("stall_mispredict", {31'd0, mispredictE}, 32'd1);
      end
      cyc(32'd0, 0, 0, 0, tk);
      cyc(32'd0, 0, 0, 0, 0);
      check("post_stall_clear", {31'd0, mispredictE}, 32'd0);
      // flushed slot never resolves
      cyc(P + 32'd8, 1, 0, 1, 0);
      cyc(32'd0, 0, 0, 0, ~q[0].p);
      check("flush_no_mispredict", {31'd0, mispredictE}, 32'd0);
      rand_cycles(400);
      cyc(P, 1, 0, 0, 1);
      #2 resetn = 1'b0;
      #1;
      check("async_rst_pred_takeE", {31'd0, pred_takeE}, 32'd0);
      check("async_rst_mispredictE", {31'd0, mispredictE}, 32'd0);
      check("async_rst_br_cnt", br_cnt, 32'd0);
      check("async_rst_mis_cnt", mis_cnt, 32'd0);
      model_reset();
      #1 resetn = 1'b1;
      rand_cycles(200);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Direction-prediction and resolution controller around the execute-stage branch judge.
- Predicts the direction of each decode-stage branch from a gshare pattern table (2-bit counters indexed by PC xor global history).
- Carries the prediction to execute and compares it with the resolved branch_takeE. Raises mispredictE, trains the table, and repairs the speculative global history.

Parameters:
- IDX_W, 6, pattern-table index width; table holds 2^IDX_W entries; both GHRs are IDX_W bits.
- CNT_INIT, 2'b01, reset value of every 2-bit counter (weakly not-taken).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- pcD  in  32  decode-stage PC.
- is_branchD  in  1  decode instruction is a conditional branch (BEQ/BNE/BGTZ/BLEZ/BLTZ/BGEZ/BLTZAL/BGEZAL).
- stallE  in  1  D->E register holds; no table/GHR commit this cycle.
- flushE  in  1  bubble inserted into E on advance.
- branch_takeE  in  1  resolved direction from the branch judge.
- pred_takeD  out  1  predicted direction for the decode branch, combinational.
- pred_takeE  out  1  registered prediction of the E-stage branch.
- mispredictE  out  1  E-stage branch resolved opposite to its prediction.
- br_cnt  out  32  resolved-branch count (see optional feature).
- mis_cnt  out  32  mispredict count (see optional feature).

Behaviour:
- Reset, asynchronous, resetn=0:
  - all counters = CNT_INIT; ghr_spec = ghr_commit = 0.
  - validE = 0, idxE = 0, pred_takeE = 0.
  - mispredictE = 0; br_cnt = mis_cnt = 0.
  - Reset mid-operation discards the in-flight branch.
- Decode lookup, combinational:
  - idxD = pcD[IDX_W+1:2] ^ ghr_spec.
  - pred_takeD = pht[idxD][1] when is_branchD, else 0.
- Advance: the cycle where stallE=0.
  - validE <= is_branchD & ~flushE & ~mispredictE.
  - idxE <= idxD; pred_takeE <= pred_takeD.
  - When stallE=1, all E registers hold.
- Resolve:
  - mispredictE = validE & (pred_takeE != branch_takeE), combinational, asserted regardless of stallE.
  - Commit occurs only on a cycle with validE=1 and stallE=0. This makes exactly one commit per branch, however long it stalls.
- Commit:
  - Taken: pht[idxE] increments, saturating at 3.
  - Not taken: pht[idxE] decrements, saturating at 0.
  - ghr_commit <= {ghr_commit[IDX_W-2:0], branch_takeE}.
- Speculative GHR:
  - On advance with is_branchD=1 and no committing mispredict: ghr_spec <= {ghr_spec[IDX_W-2:0], pred_takeD}.
  - A committing mispredict overrides this in the same cycle: ghr_spec <= {ghr_commit[IDX_W-2:0], branch_takeE}. The decode-side shift is discarded because that instruction is wrong-path.
  - On a committing correct prediction, the decode shift (if any) applies normally.
- Same-cycle read/write of one index: the decode read returns the old counter (no bypass).
- Flush semantics:
  - flushE with stallE=0 yields validE=0 next cycle and no table/GHR commit for the flushed slot.
  - ghr_spec is not repaired by flushE. Only a mispredict repairs it.
- Latency:
  - prediction 0 cycles (combinational in D).
  - mispredict visible in E one advance after D.
  - table update visible to decode lookups the cycle after commit.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - br_cnt increments by 1 on every commit.
  - mis_cnt increments by 1 on every committing mispredict.
  - Both are 32-bit, wrap 0xFFFFFFFF->0, and reset to 0.
- Undefined: counters not instantiated; br_cnt and mis_cnt tied to 0; ports retained.

Test Plan:
- Cold prediction and training (after reset, IDX_W=6):
  - pcD=0x00400010, is_branchD=1 -> idxD=4, pred_takeD=0.
  - Next cycle branch_takeE=1 -> mispredictE=1, pht[4]=2'b10, ghr_commit=ghr_spec=6'b000001.
- GHR effect on index: same pcD again -> idxD=5, pred_takeD=0 (pht[5]=01).
- Saturation:
  - Same index resolved taken 4 times with GHR forced constant via interleaved not-taken -> counter 01->10->11->11, pred_takeD=1 from the 2nd lookup.
  - 3 not-taken -> counter reaches 00 and stays.
- Stall hold: validE=1 mispredicting, stallE=1 for 3 cycles.
  - mispredictE=1 every cycle; pht and ghr_commit unchanged.
  - Single update on the cycle stallE drops.
- Flush/repair interaction:
  - flushE during advance -> validE=0, no update.
  - Mispredict commit coinciding with a new decode branch -> ghr_spec = {ghr_commit[4:0], branch_takeE} and the next validE=0.
- Stats (BP_STATS_EN): 10 branches, 3 mispredicts -> br_cnt=10, mis_cnt=3. Async resetn pulse mid-run -> both 0 and validE=0 immediately.
